bcd2bin_seq: RTL and testbench

Sequential 3-digit BCD-to-binary converter; the inverse of the team's combinational 8-bit binary-to-BCD block. It accepts a 10-bit packed BCD value {hundreds[1:0], tens[3:0], units[3:0]} over a valid/ready handshake. It computes the binary value by iterative multiply-by-ten-and-add over three cycles, then presents an 8-bit result with an error flag on a second valid/ready handshake. It sits on the input side of the datapath, where operator/display-format decimal values re-enter the binary domain.

---
 rtl/bcd2bin_seq.sv | 111 +++++++++++
 tb/tb_bcd2bin_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// Sequential 3-digit BCD-to-binary converter: multiply-by-ten-and-add over three
// cycles between an input valid/ready handshake and an output valid/ready handshake.
module bcd2bin_seq #(
  parameter bit ERR_SAT = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_bcd_in,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic [7:0] o_bin_out,
  output logic       o_err,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [2:0] o_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and data is held stable while valid is high.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HUND  = 3'd1,
    S_TENS  = 3'd2,
    S_UNITS = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     r_state;
  logic [9:0] r_bcd;
  logic [8:0] r_acc;
  logic       r_err_flag;
  logic       r_in_ready;
  logic       r_out_valid;
  logic [7:0] r_bin_out;
  logic       r_err;

  logic [3:0] w_digit;
  logic       w_digit_bad;
  logic [8:0] w_acc_x10;
  logic [8:0] w_acc_mac;
  logic       w_err_final;

  // The same multiply-add serves both the tens and the units step.
  assign w_digit     = (r_state == S_TENS) ? r_bcd[7:4] : r_bcd[3:0];
  assign w_digit_bad = (w_digit > 4'd9);
  assign w_acc_x10   = (r_acc << 3) + (r_acc << 1);
  assign w_acc_mac   = w_acc_x10 + {5'b0_0000, w_digit};
  assign w_err_final = r_err_flag | w_digit_bad | w_acc_mac[8];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_bcd       <= '0;
      r_acc       <= '0;
      r_err_flag  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bin_out   <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_bcd      <= i_bcd_in;
            r_acc      <= '0;
            r_err_flag <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_HUND;
          end
        end
        S_HUND: begin
          r_acc   <= {7'b000_0000, r_bcd[9:8]};
          r_state <= S_TENS;
        end
        S_TENS: begin
          r_acc      <= w_acc_mac;
          r_err_flag <= r_err_flag | w_digit_bad;
          r_state    <= S_UNITS;
        end
        S_UNITS: begin
          // Result is registered here so it is stable for the whole DONE period.
          r_acc       <= w_acc_mac;
          r_err_flag  <= r_err_flag | w_digit_bad;
          r_err       <= w_err_final;
          r_bin_out   <= (ERR_SAT && w_err_final) ? 8'hFF : w_acc_mac[7:0];
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_bin_out   = r_bin_out;
  assign o_err       = r_err;
  assign o_state     = r_state;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed and randomized checks of bcd2bin_seq with saturating and raw error modes.
module tb_bcd2bin_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] bcd_in = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, err;
  logic [7:0] bin_out;
  logic [2:0] state;
  logic       in_ready_r, out_valid_r, err_r;
  logic [7:0] bin_out_r;
  logic [2:0] state_r;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  bcd2bin_seq #(.ERR_SAT(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_bcd_in(bcd_in), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .o_bin_out(bin_out), .o_err(err), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_state(state)
  );

  bcd2bin_seq #(.ERR_SAT(1'b0)) dut_raw (
    .i_clk(clk), .i_rst_n(rst_n), .i_bcd_in(bcd_in), .i_in_valid(in_valid),
    .o_in_ready(in_ready_r), .o_bin_out(bin_out_r), .o_err(err_r), .o_out_valid(out_valid_r),
    .i_out_ready(out_ready), .o_state(state_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {err, saturated result, raw low byte}
  function automatic logic [16:0] model(input logic [9:0] b);
    int   v;
    logic e;
    v = int'(b[9:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    e = (b[7:4] > 4'd9) || (b[3:0] > 4'd9) || (v > 255);
    return {e, (e ? 8'hFF : v[7:0]), v[7:0]};
  endfunction

  task automatic send(input logic [9:0] bcd);
    @(negedge clk);
    bcd_in   = bcd;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_busy", in_ready, 0);
  endtask

  task automatic wait_out();
    int k = 1;
    while (!out_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 4);
  endtask

  task automatic check_out(input string tag, input logic [7:0] eb, input logic ee, input logic [7:0] er);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_bin"}, bin_out, eb);
    chk({tag, "_err"}, err, ee);
    chk({tag, "_raw"}, bin_out_r, er);
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] e;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    out_ready = 1'b1;
    send(10'h000);
    wait_out();
    check_out("zero", 8'h00, 1'b0, 8'h00);
    finish_out();

    send(10'h255); wait_out(); check_out("d255", 8'hFF, 1'b0, 8'hFF); finish_out();
    send(10'h123); wait_out(); check_out("d123", 8'h7B, 1'b0, 8'h7B); finish_out();
    send(10'h256); wait_out(); check_out("d256", 8'hFF, 1'b1, 8'h00); finish_out();
    send(10'h0A0); wait_out(); check_out("tensA", 8'hFF, 1'b1, 8'h64); finish_out();

    // Backpressure with input noise
    send(10'h321);
    wait_out();
    for (int i = 0; i < 6; i++) begin
      bcd_in   = 10'($urandom_range(0, 1023));
      in_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_bin", bin_out, 8'hFF);
      chk("bp_err", err, 1);
      chk("bp_raw", bin_out_r, 8'h41);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    check_out("d321", 8'hFF, 1'b1, 8'h41);
    finish_out();

    // in_valid during output handshake is taken only on the following cycle
    send(10'h099);
    wait_out();
    check_out("d099", 8'h63, 1'b0, 8'h63);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    bcd_in    = 10'h199;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_valid_drop", out_valid, 0);
    chk("hs_not_taken", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("hs_taken_next", in_ready, 0);
    wait_out();
    check_out("d199", 8'hC7, 1'b0, 8'hC7);
    finish_out();

    // Reset while in TENS
    send(10'h255);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_bin", bin_out, 0);
    chk("midrst_err", err, 0);
    repeat (4) @(negedge clk);
    chk("midrst_no_pulse", out_valid, 0);
    send(10'h042); wait_out(); check_out("d042", 8'h2A, 1'b0, 8'h2A); finish_out();

    // Reset while holding a result in DONE
    send(10'h256);
    wait_out();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("donerst_valid", out_valid, 0);
    chk("donerst_bin", bin_out, 0);
    chk("donerst_err", err, 0);

    // Every code with random gaps on both handshakes
    for (int c = 0; c < 1024; c++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      exp_q.push_back(model(10'(c)));
      send(10'(c));
      wait_out();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      e = exp_q.pop_front();
      check_out("rand", e[15:8], e[16], e[7:0]);
      finish_out();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
